// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALU codes, alu_op classes,
// funct7 patterns and the controller state type.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_MD    = 4'b1100;
    localparam logic [3:0] ALU_INV   = 4'b1111;

    localparam logic [1:0] AOP_MEM   = 2'b00;
    localparam logic [1:0] AOP_BR    = 2'b01;
    localparam logic [1:0] AOP_ARITH = 2'b10;
    localparam logic [1:0] AOP_LUI   = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       md;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_seq_muldiv.sv
// Iterative RV32M unit: XLEN-step shift-add multiply and restoring divide
// on operand magnitudes, with sign correction folded into the final step.
module muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   mcand;
    logic [CW-1:0]     cnt;
    logic              busy;
    logic              neg;
    logic              is_div;
    logic              sel_hi;

    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_pick;
    logic [XLEN-1:0]   res_nx;

    // funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1x0 signed div/rem
    always_comb begin
        a_signed = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        b_signed = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        sa       = a_signed & a[XLEN-1];
        sb       = b_signed & b[XLEN-1];
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand};
        if (!is_div)
            acc_step = {mul_sum, acc[XLEN-1:1]};
        else if (!div_diff[XLEN])
            acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};

        prod_fix = neg ? -acc_step : acc_step;
        div_pick = sel_hi ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        if (is_div)
            res_nx = neg ? -div_pick : div_pick;
        else
            res_nx = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end

    // done flags the final iteration so the result register and the
    // controller's DONE transition land on the same edge
    assign done = busy && (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            neg    <= 1'b0;
            is_div <= 1'b0;
            sel_hi <= 1'b0;
            result <= '0;
        end else if (start) begin
            cnt    <= CW'(XLEN);
            busy   <= 1'b1;
            is_div <= op[2];
            if (op[2]) begin
                acc    <= {{XLEN{1'b0}}, mag_a};
                mcand  <= mag_b;
                sel_hi <= op[1];
                // quotient of x/0 stays all ones; remainder follows the dividend
                neg    <= op[1] ? sa : ((sa ^ sb) && (b != '0));
            end else begin
                acc    <= {{XLEN{1'b0}}, mag_b};
                mcand  <= mag_a;
                sel_hi <= (op[1:0] != 2'b00);
                neg    <= sa ^ sb;
            end
        end else if (busy) begin
            acc <= acc_step;
            cnt <= cnt - CW'(1);
            if (done) begin
                busy   <= 1'b0;
                result <= res_nx;
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with valid/ready handshake; RV32M ops are executed on
// the iterative muldiv unit while the core stalls.
//   state | meaning
//   IDLE  | ready for a request, decode on accept
//   CALC  | muldiv iterating, in_ready low
//   DONE  | outputs valid, held until out_ready
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            is_imm,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_ctrl,
    output logic            md_sel,
    output logic [XLEN-1:0] md_result,
    output logic            illegal
);

    function automatic dec_t decode(input logic [1:0] aop, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic imm);
        logic [3:0] c;
        logic       md;
        c  = ALU_INV;
        md = 1'b0;
        case (aop)
            AOP_MEM: c = ALU_ADD;
            AOP_LUI: c = ALU_PASSB;
            AOP_BR: begin
                case (f3)
                    3'b000, 3'b001: c = ALU_SUB;
                    3'b100, 3'b101: c = ALU_SLT;
                    3'b110, 3'b111: c = ALU_SLTU;
                    default:        c = ALU_INV;
                endcase
            end
            AOP_ARITH: begin
                if (!imm && f7 == F7_MULDIV) begin
                    if (ENABLE_M) begin
                        c  = ALU_MD;
                        md = 1'b1;
                    end
                end else if (!imm && f7 != F7_BASE && f7 != F7_ALT) begin
                    c = ALU_INV;
                end else if (!imm && f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101) begin
                    c = ALU_INV;
                end else if (imm && (f3 == 3'b001 || f3 == 3'b101)
                             && f7 != F7_BASE && f7 != F7_ALT) begin
                    c = ALU_INV;
                end else begin
                    case (f3)
                        3'b000:  c = (!imm && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        3'b001:  c = ALU_SLL;
                        3'b010:  c = ALU_SLT;
                        3'b011:  c = ALU_SLTU;
                        3'b100:  c = ALU_XOR;
                        3'b101:  c = f7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  c = ALU_OR;
                        default: c = ALU_AND;
                    endcase
                end
            end
            default: c = ALU_INV;
        endcase
        return '{ctrl: c, md: md, illegal: (c == ALU_INV)};
    endfunction

    state_t state, state_nx;
    dec_t   dec;
    logic   md_start;
    logic   md_done;

    assign dec       = decode(alu_op, funct3, funct7, is_imm);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        md_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (dec.md) begin
                        state_nx = ST_CALC;
                        md_start = 1'b1;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_CALC: if (md_done)   state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctrl <= ALU_ADD;
            md_sel   <= 1'b0;
            illegal  <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            alu_ctrl <= dec.ctrl;
            md_sel   <= dec.md;
            illegal  <= dec.illegal;
        end
    end

    generate
        if (ENABLE_M) begin : g_md
            muldiv_iter #(.XLEN(XLEN)) u_muldiv (
                .clk    (clk),
                .rst    (rst),
                .start  (md_start),
                .op     (funct3),
                .a      (op_a),
                .b      (op_b),
                .done   (md_done),
                .result (md_result)
            );
        end else begin : g_no_md
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised successor to the single-cycle ALU control decoder for the RISC-V core.
- Decodes ALUOp/funct3/funct7 into the 4-bit ALU control code, extends the code set with SLT/SLTU, branch-type compares and pass-B, and handles RV32M.
- RV32M ops (MUL*/DIV*/REM*) run on an internal iterative multiply/divide unit.
- Uses a valid/ready handshake so the core stalls during multi-cycle ops. Sits between the main decoder and the execute stage.

Parameters:
XLEN, 32, operand/result width (power of two, >= 8)
ENABLE_M, 1, 1 = RV32M executed internally; 0 = M encodings flagged illegal

Ports:
clk  input  1  clock
rst  input  1  reset (clears all state)
in_valid  input  1  request present
in_ready  output  1  block can accept a request
alu_op  input  2  00 load/store, 01 branch, 10 R/I-type, 11 LUI
funct3  input  3  instruction funct3
funct7  input  7  instruction funct7 (full field)
is_imm  input  1  I-type ALU instruction
op_a  input  XLEN  rs1 value (used by M ops only)
op_b  input  XLEN  rs2 value (used by M ops only)
out_valid  output  1  result/code available
out_ready  input  1  consumer accepts output
alu_ctrl  output  4  ALU control code
md_sel  output  1  1 = md_result replaces ALU result
md_result  output  XLEN  RV32M result
illegal  output  1  unsupported encoding (alu_ctrl = 1111)

Behaviour:
- The interface has one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready 1, out_valid 0, alu_ctrl 0000, md_sel 0, md_result 0, illegal 0.
- Reset asserted mid-operation aborts the op. The next cycle is IDLE and no output is produced.
- Codes:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111
  - SLT 1000, SLTU 1001, PASSB 1010, MD 1100, invalid 1111
- Decode by alu_op:
  - alu_op 00: ADD.
  - alu_op 11: PASSB.
  - alu_op 01, by funct3: 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> invalid.
  - alu_op 10, funct7 = 0000000 (or is_imm=1), by funct3:
    - 000: ADD. SUB only when funct7 = 0100000 and is_imm = 0. ADDI is always ADD.
    - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
    - 101: SRL, or SRA when funct7[5] = 1. This applies to both R-type and I-type.
    - 110: OR. 111: AND.
  - alu_op 10, is_imm = 0, funct7 = 0000001: M op.
    - If ENABLE_M = 0: alu_ctrl 1111, illegal 1.
    - Otherwise: alu_ctrl MD, md_sel 1.
  - Any other funct7 with alu_op 10 and is_imm = 0: invalid.
  - For I-type shifts, funct7 must be 0000000 or 0100000, else invalid.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready = 1. On in_valid, the request is registered.
    - Non-M or illegal op -> DONE. out_valid rises on the next cycle (latency 1).
    - M op -> CALC. op_a/op_b are latched, and the operands are converted to magnitudes for signed variants.
  - CALC: in_ready = 0. Runs exactly XLEN iterations: shift-add for multiply, restoring divide for divide. Then -> DONE, with the result sign-corrected.
    - M-op latency is XLEN+1 cycles from the accept edge to out_valid.
  - DONE: out_valid = 1 and outputs are held stable until out_ready. On out_ready -> IDLE.
    - No new request is accepted in the same cycle as the output handshake. in_ready rises the cycle after.
- Multiply: 2*XLEN-bit product.
  - MUL returns the low half.
  - MULH treats both operands as signed; MULHSU as a signed, b unsigned; MULHU as both unsigned. All three return the high half.
- Divide corner cases (RISC-V spec):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Signed overflow (op_a = 1 followed by XLEN-1 zeros, op_b = all ones): DIV -> op_a, REM -> 0.
  - These cases still take the full XLEN+1 latency.
- Outputs are registered. alu_ctrl, md_sel and illegal are valid only while out_valid = 1.

Decomposition:
- Package alu_ctrl_pkg holds:
  - the ALU code localparams (ADD..invalid)
  - the alu_op encodings
  - the funct7 constants 0000000, 0100000, 0000001
  - the FSM state enum
- The decode logic stays inline as a combinational function.
- One sub-module: muldiv_iter. It contains the XLEN-cycle shift-add/restoring datapath and its iteration counter. Interface: start, op[2:0], a, b, done, result.

Test Plan:
- R-type sweep: alu_op=10, funct7 = 0000000/0100000, all funct3. Expect out_valid 1 cycle after accept and codes per the table, e.g. funct3=101, funct7=0100000 -> 0111. Then ADDI with funct7=0100000 -> 0000.
- Branch and LUI: alu_op=01 with funct3 = 000/100/110/010 -> 0001/1000/1001/1111 (illegal=1). alu_op=11 -> 1010.
- MUL/MULH: a=0xFFFFFFFE, b=3. Expect MUL 0xFFFFFFFA, MULH 0xFFFFFFFF, MULHU 0x00000002. out_valid exactly 33 cycles after accept; in_ready 0 throughout.
- Divide corners:
  - DIV 7/-2 -> 0xFFFFFFFD, REM -> 1.
  - DIVU x/0 -> 0xFFFFFFFF, REMU x/0 -> x.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Outputs stay stable and in_ready stays 0. Release; in_ready=1 on the next cycle.
- Reset mid-CALC: rst=1 at cycle 10 of a DIV. Next cycle out_valid=0, in_ready=1, no stale result. Then ENABLE_M=0 build: MUL -> alu_ctrl 1111, illegal 1, latency 1.
